// File: rtl/estagio_acesso_memoria.sv
// estagio_acesso_memoria: nRisc memory-access stage with FIFO store buffer and port arbitration.
// Define ENCAMINHAMENTO_STORE_EN for store-to-load forwarding; otherwise matching loads wait for drain.
module estagio_acesso_memoria #(
    parameter int LARGURA_DADO = 8,
    parameter int LARGURA_END  = 8,
    parameter int LARGURA_REG  = 2,
    parameter int PROF_BUFFER  = 4
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           ReqValido,
    output logic                           ReqPronto,
    input  logic                           ReqEscrita,
    input  logic [LARGURA_END-1:0]         ReqEndereco,
    input  logic [LARGURA_DADO-1:0]        ReqDado,
    input  logic [LARGURA_REG-1:0]         ReqRegDest,
    output logic [LARGURA_END-1:0]         Endereco,
    output logic [LARGURA_DADO-1:0]        DadoEscritoMem,
    output logic                           EscMem,
    output logic                           LerMem,
    input  logic [LARGURA_DADO-1:0]        DadoLidoMem,
    output logic                           RespValido,
    output logic [LARGURA_DADO-1:0]        RespDado,
    output logic [LARGURA_REG-1:0]         RespRegDest,
    output logic [$clog2(PROF_BUFFER):0]   Ocupacao,
    output logic                           BufferVazio
);
    localparam int PW = $clog2(PROF_BUFFER);
    localparam int CW = PW + 1;

    logic [LARGURA_END-1:0]  buf_end  [PROF_BUFFER];
    logic [LARGURA_DADO-1:0] buf_dado [PROF_BUFFER];
    logic [PW-1:0]           cabeca, cauda;
    logic                    cheio, eh_load, load_ok, acerto, drena, le, empurra;
    logic [LARGURA_DADO-1:0] dado_sel;
`ifdef ENCAMINHAMENTO_STORE_EN
    logic [LARGURA_DADO-1:0] dado_fwd;
`endif

    // Ascending scan from head, so the last hit is the youngest matching store.
    always_comb begin
        acerto = 1'b0;
`ifdef ENCAMINHAMENTO_STORE_EN
        dado_fwd = '0;
`endif
        for (int i = 0; i < PROF_BUFFER; i++) begin
            if (CW'(i) < Ocupacao && buf_end[cabeca + PW'(i)] == ReqEndereco) begin
                acerto = 1'b1;
`ifdef ENCAMINHAMENTO_STORE_EN
                dado_fwd = buf_dado[cabeca + PW'(i)];
`endif
            end
        end
    end

`ifdef ENCAMINHAMENTO_STORE_EN
    assign load_ok  = 1'b1;
    assign dado_sel = acerto ? dado_fwd : DadoLidoMem;
`else
    assign load_ok  = ~acerto;
    assign dado_sel = DadoLidoMem;
`endif

    assign BufferVazio = Ocupacao == '0;
    assign cheio       = Ocupacao == CW'(PROF_BUFFER);
    assign eh_load     = ReqValido & ~ReqEscrita;
    assign le          = ~cheio & eh_load & load_ok;
    // A load blocked by a matching entry falls through to draining.
    assign drena       = cheio | (~le & ~BufferVazio);

    assign ReqPronto      = ~Reset & ~cheio & ~(eh_load & ~load_ok);
    assign EscMem         = ~Reset & drena;
    assign LerMem         = ~Reset & le;
    assign Endereco       = EscMem ? buf_end[cabeca] : LerMem ? ReqEndereco : '0;
    assign DadoEscritoMem = EscMem ? buf_dado[cabeca] : '0;
    assign empurra        = ReqPronto & ReqValido & ReqEscrita;

    always_ff @(posedge Clock) begin
        if (empurra) begin
            buf_end[cauda]  <= ReqEndereco;
            buf_dado[cauda] <= ReqDado;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cabeca      <= '0;
            cauda       <= '0;
            Ocupacao    <= '0;
            RespValido  <= 1'b0;
            RespDado    <= '0;
            RespRegDest <= '0;
        end else begin
            if (empurra)
                cauda <= cauda + 1'b1;
            if (EscMem)
                cabeca <= cabeca + 1'b1;
            Ocupacao   <= Ocupacao + CW'(empurra) - CW'(EscMem);
            RespValido <= LerMem;
            if (LerMem) begin
                RespDado    <= dado_sel;
                RespRegDest <= ReqRegDest;
            end
        end
    end
endmodule

// File: tb/tb_estagio_acesso_memoria.sv
// tb_estagio_acesso_memoria: random and directed checks against an architectural memory model
// plus a FIFO model of pending stores; the data memory lives in the bench.
module tb_estagio_acesso_memoria;
    localparam int PROF = 4;
`ifdef ENCAMINHAMENTO_STORE_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {logic [7:0] a; logic [7:0] d;} st_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic       req_valido = 0, req_escrita = 0, req_pronto;
    logic [7:0] req_end = 0, req_dado = 0;
    logic [1:0] req_reg = 0;
    logic [7:0] endereco, dado_escrito, dado_lido, resp_dado;
    logic       esc_mem, ler_mem, resp_valido, buffer_vazio;
    logic [1:0] resp_reg;
    logic [2:0] ocupacao;

    logic [7:0] mem [256];
    logic [7:0] arch [256];
    logic [7:0] mref [256];
    st_t        q [$];
    int         nvec = 0, nerr = 0;

    estagio_acesso_memoria dut (
        .Clock(clk), .Reset(rst), .ReqValido(req_valido), .ReqPronto(req_pronto),
        .ReqEscrita(req_escrita), .ReqEndereco(req_end), .ReqDado(req_dado),
        .ReqRegDest(req_reg), .Endereco(endereco), .DadoEscritoMem(dado_escrito),
        .EscMem(esc_mem), .LerMem(ler_mem), .DadoLidoMem(dado_lido),
        .RespValido(resp_valido), .RespDado(resp_dado), .RespRegDest(resp_reg),
        .Ocupacao(ocupacao), .BufferVazio(buffer_vazio)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        forever begin
            @(posedge clk);
            if (esc_mem) mem[endereco] <= dado_escrito;
        end
    end

    initial begin
        dado_lido = '0;
        forever begin
            @(negedge clk);
            if (ler_mem) dado_lido <= mem[endereco];
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit v, input bit w, input logic [7:0] a, input logic [7:0] d,
                        input logic [1:0] r, output bit acc);
        bit full, hit, rdy, rd, wr;
        st_t h;
        logic [7:0] ld;
        req_valido = v; req_escrita = w; req_end = a; req_dado = d; req_reg = r;
        @(negedge clk); #1;
        full = q.size() == PROF;
        hit = 0;
        foreach (q[i]) if (q[i].a == a) hit = 1;
        h = q.size() != 0 ? q[0] : st_t'{8'h0, 8'h0};
        rdy = !full && !(v && !w && !FWD && hit);
        rd = v && !w && rdy;
        wr = full || (!rd && q.size() != 0);
        if (v) chk("pronto", 32'(req_pronto), 32'(rdy));
        chk("lermem", 32'(ler_mem), 32'(rd));
        chk("escmem", 32'(esc_mem), 32'(wr));
        chk("endereco", 32'(endereco), wr ? 32'(h.a) : rd ? 32'(a) : 0);
        chk("dadoesc", 32'(dado_escrito), wr ? 32'(h.d) : 0);
        acc = v && rdy;
        ld = arch[a];
        @(posedge clk); #1;
        if (wr) begin
            mref[h.a] = h.d;
            void'(q.pop_front());
            chk("mem", 32'(mem[h.a]), 32'(h.d));
        end
        if (acc && w) begin
            q.push_back(st_t'{a, d});
            arch[a] = d;
        end
        chk("respvalido", 32'(resp_valido), 32'(acc && !w));
        if (acc && !w) begin
            chk("respdado", 32'(resp_dado), 32'(ld));
            chk("respreg", 32'(resp_reg), 32'(r));
        end
        chk("ocupacao", 32'(ocupacao), 32'(q.size()));
        chk("vazio", 32'(buffer_vazio), 32'(q.size() == 0));
    endtask

    task automatic req(input bit w, input logic [7:0] a, input logic [7:0] d, input logic [1:0] r);
        bit acc;
        for (int k = 0; k < 10; k++) begin
            step(1, w, a, d, r, acc);
            if (acc) return;
        end
        chk("req_timeout", 0, 1);
    endtask

    task automatic idle();
        bit acc;
        step(0, 0, 8'h0, 8'h0, 2'h0, acc);
    endtask

    initial begin
        bit acc, v, w;
        logic [7:0] a, d;
        logic [1:0] r;
        for (int i = 0; i < 256; i++) begin
            arch[i] = 8'(i) ^ 8'hA5;
            mref[i] = 8'(i) ^ 8'hA5;
        end
        #12;
        chk("rst_respvalido", 32'(resp_valido), 0);
        chk("rst_respdado", 32'(resp_dado), 0);
        chk("rst_respreg", 32'(resp_reg), 0);
        chk("rst_ocupacao", 32'(ocupacao), 0);
        chk("rst_vazio", 32'(buffer_vazio), 1);
        chk("rst_pronto", 32'(req_pronto), 0);
        chk("rst_escmem", 32'(esc_mem), 0);
        chk("rst_lermem", 32'(ler_mem), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        req(1, 8'h10, 8'h5A, 0);
        idle();
        req(1, 8'h20, 8'h11, 0);
        req(1, 8'h20, 8'h22, 0);
        req(0, 8'h20, 8'h00, 3);
        for (int i = 0; i < 5; i++) req(1, 8'h60 + 8'(i), 8'hC0 + 8'(i), 0);
        for (int i = 0; i < 8; i++)
            if (i % 2 == 0) req(0, 8'h30, 8'h00, 1);
            else req(1, 8'h70 + 8'(i), 8'(i), 0);
        idle();
        req(1, 8'h41, 8'h3C, 0);
        req(0, 8'h40, 8'h00, 2);
        idle();

        v = 0; w = 0; a = 0; d = 0; r = 0;
        acc = 1;
        for (int n = 0; n < 1500; n++) begin
            if (acc || !v) begin
                v = ($urandom % 4) != 0;
                w = $urandom % 2;
                a = 8'h10 + 8'($urandom % 8);
                d = 8'($urandom);
                r = 2'($urandom);
            end
            step(v, w, a, d, r, acc);
        end
        idle();

        // Asynchronous reset while the only buffered store is being drained.
        req(1, 8'h50, 8'h99, 0);
        req_valido = 0;
        @(negedge clk); #1;
        chk("pre_rst_escmem", 32'(esc_mem), 1);
        rst = 1'b1;
        #1;
        chk("rst2_ocupacao", 32'(ocupacao), 0);
        chk("rst2_vazio", 32'(buffer_vazio), 1);
        chk("rst2_escmem", 32'(esc_mem), 0);
        chk("rst2_lermem", 32'(ler_mem), 0);
        chk("rst2_pronto", 32'(req_pronto), 0);
        chk("rst2_respdado", 32'(resp_dado), 0);
        q.delete();
        for (int i = 0; i < 256; i++) arch[i] = mref[i];
        @(posedge clk); #1;
        for (int i = 8'h10; i < 8'h80; i++) chk("rst2_mem", 32'(mem[i]), 32'(mref[i]));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        req(0, 8'h50, 8'h00, 1);
        req(0, 8'h10, 8'h00, 2);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
